// File: rtl/gpio_pattern_gen_if.sv
// Control and pattern-output bundle between the board top and gpio_pattern_gen.
// The slave side is the generator; the master side drives enable and mode.
interface gpio_pattern_gen_if #(
  parameter int NUM_PINS = 32
);
  logic                enable_i;
  logic [1:0]          mode_i;
  logic [NUM_PINS-1:0] gpio_o;
  logic [1:0]          mode_o;
  logic                frame_o;

  modport master (
    output enable_i,
    output mode_i,
    input  gpio_o,
    input  mode_o,
    input  frame_o
  );

  modport slave (
    input  enable_i,
    input  mode_i,
    output gpio_o,
    output mode_o,
    output frame_o
  );
endinterface

// File: rtl/gpio_pattern_gen.sv
// GPIO test-pattern generator: walking one, per-pin serial ID, binary divider
// and checkerboard patterns, stepped by an internal prescaler tick.
module gpio_pattern_gen #(
  parameter int NUM_PINS = 32,
  parameter int TICK_DIV = 12000,
  parameter int GAP_BITS = 4,
  parameter int DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_pattern_gen_if.slave bus
);

  localparam int IDW       = $clog2(NUM_PINS);
  localparam int FRAME_LEN = IDW + 2 + GAP_BITS;
  localparam int STEP_MAX  = (NUM_PINS > FRAME_LEN) ? NUM_PINS : FRAME_LEN;
  localparam int SW        = $clog2(STEP_MAX);
  localparam int PW        = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_WALK    = 2'd0,
    MODE_ID      = 2'd1,
    MODE_DIVIDE  = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  logic [PW-1:0]       presc_r;
  logic [SW-1:0]       step_r;
  logic [DIV_W-1:0]    cnt_r;
  logic                phase_r;
  mode_e               mode_r;
  logic                wrap_r;
  logic [NUM_PINS-1:0] gpio_r;
  logic                frame_r;

  logic                tick_s;
  logic                boundary_s;
  mode_e               mode_req_s;
  logic [SW-1:0]       step_nxt_s;
  logic [DIV_W-1:0]    cnt_nxt_s;
  logic                phase_nxt_s;
  mode_e               mode_nxt_s;
  logic                wrap_nxt_s;
  logic [NUM_PINS-1:0] pattern_s;

  // Serial ID bit for one pin: start 0, index LSB first, then stop/idle 1s.
  function automatic logic id_bit(input int pin, input int step);
    logic bit_v;
    if (step == 0) begin
      bit_v = 1'b0;
    end else if (step <= IDW) begin
      bit_v = (((pin >> (step - 1)) % 2) == 1);
    end else begin
      bit_v = 1'b1;
    end
    return bit_v;
  endfunction

  assign tick_s     = (presc_r == PW'(TICK_DIV - 1));
  assign mode_req_s = mode_e'(bus.mode_i);

  // Next pattern state: a tick either applies a pending mode change at a
  // boundary (ID only switches at its last step) or advances the active mode.
  always_comb begin
    step_nxt_s  = step_r;
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    mode_nxt_s  = mode_r;
    wrap_nxt_s  = 1'b0;
    if (mode_r == MODE_ID) begin
      boundary_s = (step_r == SW'(FRAME_LEN - 1));
    end else begin
      boundary_s = 1'b1;
    end
    if (tick_s) begin
      if ((mode_req_s != mode_r) && boundary_s) begin
        mode_nxt_s  = mode_req_s;
        step_nxt_s  = '0;
        cnt_nxt_s   = '0;
        phase_nxt_s = 1'b0;
        wrap_nxt_s  = 1'b1;
      end else begin
        case (mode_r)
          MODE_WALK: begin
            if (step_r == SW'(NUM_PINS - 1)) begin
              step_nxt_s = '0;
              wrap_nxt_s = 1'b1;
            end else begin
              step_nxt_s = step_r + SW'(1);
            end
          end
          MODE_ID: begin
            if (step_r == SW'(FRAME_LEN - 1)) begin
              step_nxt_s = '0;
              wrap_nxt_s = 1'b1;
            end else begin
              step_nxt_s = step_r + SW'(1);
            end
          end
          MODE_DIVIDE: begin
            cnt_nxt_s  = cnt_r + DIV_W'(1);
            wrap_nxt_s = &cnt_r;
          end
          MODE_CHECKER: begin
            phase_nxt_s = ~phase_r;
            wrap_nxt_s  = phase_r;
          end
          default: begin
            step_nxt_s = '0;
          end
        endcase
      end
    end else begin
      wrap_nxt_s = 1'b0;
    end
  end

  // Pin pattern for the current state; registered below, so it lags by one cycle.
  always_comb begin
    pattern_s = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      case (mode_r)
        MODE_WALK:    pattern_s[i] = (int'(step_r) == i);
        MODE_ID:      pattern_s[i] = id_bit(i, int'(step_r));
        MODE_DIVIDE:  pattern_s[i] = (((int'(cnt_r) >> (i % DIV_W)) & 1) != 0);
        MODE_CHECKER: pattern_s[i] = phase_r ^ ((i % 2) == 1);
        default:      pattern_s[i] = 1'b0;
      endcase
    end
  end

  // State, prescaler and outputs; frame_r follows wrap_r so it lines up with step 0 on gpio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
      step_r  <= '0;
      cnt_r   <= '0;
      phase_r <= 1'b0;
      mode_r  <= MODE_WALK;
      wrap_r  <= 1'b0;
      gpio_r  <= '0;
      frame_r <= 1'b0;
    end else if (!bus.enable_i) begin
      presc_r <= '0;
      step_r  <= '0;
      cnt_r   <= '0;
      phase_r <= 1'b0;
      mode_r  <= mode_req_s;
      wrap_r  <= 1'b0;
      gpio_r  <= '0;
      frame_r <= 1'b0;
    end else begin
      presc_r <= tick_s ? '0 : presc_r + PW'(1);
      step_r  <= step_nxt_s;
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
      mode_r  <= mode_nxt_s;
      wrap_r  <= wrap_nxt_s;
      gpio_r  <= pattern_s;
      frame_r <= wrap_r;
    end
  end

  assign bus.gpio_o  = gpio_r;
  assign bus.mode_o  = mode_r;
  assign bus.frame_o = frame_r;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Directed bench for gpio_pattern_gen with 8 pins, 4-cycle steps, 3 gap bits
// (ID frame of 8 steps) and a 4-bit divider counter.
module tb_gpio_pattern_gen;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  gpio_pattern_gen_if #(.NUM_PINS(8)) bus ();

  gpio_pattern_gen #(
    .NUM_PINS(8),
    .TICK_DIV(4),
    .GAP_BITS(3),
    .DIV_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pin5_exp;
    logic [7:0] pin0_exp;
    logic [7:0] id_word [8];
    logic [3:0] kk;
    int         pulses;

    pin5_exp = 8'hFA;
    pin0_exp = 8'hF0;
    id_word[0] = 8'h00; id_word[1] = 8'hAA; id_word[2] = 8'hCC; id_word[3] = 8'hF0;
    id_word[4] = 8'hFF; id_word[5] = 8'hFF; id_word[6] = 8'hFF; id_word[7] = 8'hFF;

    rst_n        = 1'b0;
    bus.enable_i = 1'b1;
    bus.mode_i   = 2'd0;
    cyc(2);
    chk("reset_gpio", bus.gpio_o, 8'h00);
    chk("reset_mode", bus.mode_o, 2'd0);
    chk("reset_frame", bus.frame_o, 1'b0);

    // WALK after reset release
    rst_n = 1'b1;
    cyc(1);
    chk("walk_step0", bus.gpio_o, 8'h01);
    chk("walk_step0_frame", bus.frame_o, 1'b0);
    cyc(4);
    chk("walk_step1", bus.gpio_o, 8'h02);
    cyc(24);
    chk("walk_step7", bus.gpio_o, 8'h80);
    cyc(3);
    chk("walk_step7_late", bus.gpio_o, 8'h80);
    chk("walk_prewrap_frame", bus.frame_o, 1'b0);
    cyc(1);
    chk("walk_wrap_gpio", bus.gpio_o, 8'h01);
    chk("walk_wrap_frame", bus.frame_o, 1'b1);
    cyc(1);
    chk("walk_frame_pulse_end", bus.frame_o, 1'b0);
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      if (bus.frame_o === 1'b1) pulses++;
    end
    chk("walk_frames_per_32", pulses, 1);

    // Disable / re-enable, including a drop mid-walk at s=3
    bus.enable_i = 1'b0;
    cyc(1);
    chk("disable_gpio", bus.gpio_o, 8'h00);
    bus.enable_i = 1'b1;
    cyc(1);
    chk("reenable_step0", bus.gpio_o, 8'h01);
    cyc(12);
    chk("walk_step3", bus.gpio_o, 8'h08);
    bus.enable_i = 1'b0;
    cyc(1);
    chk("drop_mid_walk_gpio", bus.gpio_o, 8'h00);
    chk("drop_mid_walk_frame", bus.frame_o, 1'b0);
    bus.enable_i = 1'b1;
    cyc(1);
    chk("reenable2_step0", bus.gpio_o, 8'h01);
    cyc(3);
    chk("reenable2_hold", bus.gpio_o, 8'h01);
    cyc(1);
    chk("reenable2_step1", bus.gpio_o, 8'h02);

    // ID mode: mode loads directly while disabled
    bus.enable_i = 1'b0;
    bus.mode_i   = 2'd1;
    cyc(1);
    chk("id_mode_load", bus.mode_o, 2'd1);
    chk("id_disabled_gpio", bus.gpio_o, 8'h00);
    bus.enable_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc((k == 0) ? 1 : 4);
      chk($sformatf("id_pin5_s%0d", k), bus.gpio_o[5], pin5_exp[k]);
      chk($sformatf("id_pin0_s%0d", k), bus.gpio_o[0], pin0_exp[k]);
      chk($sformatf("id_word_s%0d", k), bus.gpio_o, id_word[k]);
    end
    cyc(4);
    chk("id_wrap_gpio", bus.gpio_o, 8'h00);
    chk("id_wrap_frame", bus.frame_o, 1'b1);

    // Deferred change ID -> CHECKER requested at s=2
    cyc(8);
    chk("id_s2_word", bus.gpio_o, 8'hCC);
    bus.mode_i = 2'd3;
    cyc(20);
    chk("deferred_mode_hold", bus.mode_o, 2'd1);
    chk("deferred_s7_word", bus.gpio_o, 8'hFF);
    cyc(3);
    chk("deferred_mode_applied", bus.mode_o, 2'd3);
    chk("deferred_frame_pre", bus.frame_o, 1'b0);
    cyc(1);
    chk("checker_phase0", bus.gpio_o, 8'hAA);
    chk("checker_change_frame", bus.frame_o, 1'b1);
    cyc(4);
    chk("checker_phase1", bus.gpio_o, 8'h55);
    chk("checker_phase1_frame", bus.frame_o, 1'b0);
    cyc(4);
    chk("checker_wrap_gpio", bus.gpio_o, 8'hAA);
    chk("checker_wrap_frame", bus.frame_o, 1'b1);

    // DIVIDE with DIV_W=4: upper nibble mirrors the counter
    bus.enable_i = 1'b0;
    bus.mode_i   = 2'd2;
    cyc(1);
    chk("div_mode_load", bus.mode_o, 2'd2);
    bus.enable_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc((k == 0) ? 1 : 4);
      kk = 4'(k);
      chk($sformatf("div_word_c%0d", k), bus.gpio_o, {kk, kk});
      chk($sformatf("div_pin4_c%0d", k), bus.gpio_o[4], bus.gpio_o[0]);
    end
    cyc(4);
    chk("div_wrap_gpio", bus.gpio_o, 8'h00);
    chk("div_wrap_frame", bus.frame_o, 1'b1);
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      if (bus.frame_o === 1'b1) pulses++;
    end
    chk("div_frames_per_64", pulses, 1);
    cyc(8);
    chk("div_c2_before_reset", bus.gpio_o, 8'h22);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gpio", bus.gpio_o, 8'h00);
    chk("async_reset_mode", bus.mode_o, 2'd0);
    chk("async_reset_frame", bus.frame_o, 1'b0);
    cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
